cam_ctrl: RTL and testbench
===========================

CAM_CTRL -- requirements
Module: cam_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 4, key width (matches cam).
REQ-002 SHALL have parameter ADDR_WIDTH, 2, entry-index width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter TOMBSTONE, 2**DATA_WIDTH-1, reserved key marking an empty entry.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-006 SHALL have ports ins_valid in 1, ins_data in DATA_WIDTH, ins_ready out 1: insert request handshake.
REQ-007 SHALL have ports del_valid in 1, del_addr in ADDR_WIDTH, del_ready out 1: delete request handshake.
REQ-008 SHALL have ports lk_valid in 1, lk_data in DATA_WIDTH, lk_ready out 1: lookup request handshake.
REQ-009 SHALL have outputs done out 1 (one-cycle completion pulse), res_addr out ADDR_WIDTH, res_hit out 1, res_dup out 1, res_err out 1.
REQ-010 SHALL have outputs count out ADDR_WIDTH+1 (valid entries), full out 1, init_busy out 1.
REQ-011 SHALL have CAM-side ports cam_we out 1, cam_din out DATA_WIDTH, cam_waddr out ADDR_WIDTH, cam_cmp_din out DATA_WIDTH, cam_busy in 1, cam_match in 1, cam_match_addr in ADDR_WIDTH.

Function
REQ-012 SHALL implement FSM states INIT, IDLE, CMP, WR, WAIT_BUSY, DONE.
REQ-013 INIT SHALL write TOMBSTONE to addresses 0..depth-1 in order, one cam_we pulse per entry, waiting in WAIT_BUSY while cam_busy=1 after each; then go to IDLE.
REQ-014 All *_ready SHALL be low outside IDLE, and in IDLE SHALL be high only for the single granted requester; a request is accepted on valid&ready.
REQ-015 Grant priority in IDLE: delete first; insert vs lookup round-robin via a last-grant flag (alternate when both pending).
REQ-016 No cam_we or new cam_cmp_din SHALL be issued while cam_busy=1.
REQ-017 CAM compare latency SHALL be 1 cycle: cam_match/cam_match_addr sampled in the cycle after cam_cmp_din is driven in CMP.
REQ-018 A hit SHALL require cam_match=1 and valid[cam_match_addr]=1.
REQ-019 Lookup: CMP -> DONE; res_hit, res_addr per REQ-018; lk_data=TOMBSTONE SHALL complete as miss without CMP (IDLE -> DONE).
REQ-020 Insert: CMP first; on hit -> DONE with res_dup=1, res_addr=hit address, no write.
REQ-021 Insert miss with free entry: WR writes ins_data at lowest-index invalid entry, sets its valid bit, count+1, WAIT_BUSY, DONE with res_addr=that index.
REQ-022 Insert when full or ins_data=TOMBSTONE: DONE with res_err=1, no CAM access.
REQ-023 Delete of a valid entry: WR writes TOMBSTONE at del_addr, clears valid, count-1; delete of an invalid entry: DONE, res_err=1, no write.
REQ-024 done SHALL pulse exactly one cycle per accepted request; res_* held until next done.
REQ-025 full SHALL equal (count == depth); count SHALL never exceed depth nor underflow.
REQ-026 cam_we SHALL be high exactly one cycle per write.

Reset
REQ-027 While rst=0 on a clock edge: state<=INIT at entry 0, valid bitmap<=0, count<=0, last-grant<=lookup, done/res_*/cam_we<=0, all *_ready<=0, init_busy<=1.
REQ-028 Reset mid-operation SHALL abort the operation without done and restart INIT on release.

Structure
REQ-029 State enum and TOMBSTONE default SHALL live in shared package cam_pkg.
REQ-030 Lowest-free-entry selection SHALL be a sub-module cam_free_enc (priority encoder over ~valid, outputs index and any_free).

Verification
REQ-031 rst low 2 cycles -> 4 writes of 15 at addr 0,1,2,3, init_busy high until done, count=0.
REQ-032 Insert 6,9,4,3 -> res_addr 0,1,2,3, count=4, full=1; insert 7 -> res_err=1, no cam_we.
REQ-033 Insert 9 again -> res_dup=1, res_addr=1, no cam_we; lookup 4 -> hit addr 2; lookup 5 -> miss; lookup 15 -> miss, no compare.
REQ-034 Delete addr 1 -> cam_we with data 15 at addr 1, count=3; lookup 9 -> miss; insert 13 -> res_addr=1.
REQ-035 ins_valid and lk_valid held together -> grants alternate; cam_busy held 3 cycles after a write -> no CAM activity until low.
REQ-036 rst low during WAIT_BUSY of an insert -> no done, count=0, INIT re-run.

Source files
------------

// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cam_pkg
// Purpose  : Shared FSM state/op encodings and tombstone default for cam_ctrl.
// Revision : 1.0
// ============================================================================
package cam_pkg;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_CMP       = 3'd2,
        ST_WR        = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_INIT = 2'd0,
        OP_INS  = 2'd1,
        OP_DEL  = 2'd2,
        OP_LK   = 2'd3
    } op_t;

    // All-ones key of the given width marks an empty entry.
    function automatic int tombstone_of(input int width);
        return (1 << width) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_free_enc.sv
`default_nettype none
// ============================================================================
// Module   : cam_free_enc
// Purpose  : Priority encoder returning the lowest-index invalid CAM entry.
// Revision : 1.0
// ============================================================================
module cam_free_enc #(
    parameter int ADDR_WIDTH = 2
) (
    input  logic [2**ADDR_WIDTH-1:0] valid,
    output logic [ADDR_WIDTH-1:0]    idx,
    output logic                     any_free
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    always_comb begin
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) idx = ADDR_WIDTH'(i);
        end
    end

    assign any_free = ~(&valid);

endmodule
`default_nettype wire

// File: rtl/cam_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cam_ctrl
// Purpose  : Insert/delete/lookup controller with valid bitmap over a 1-cycle CAM.
// Revision : 1.0
// ============================================================================
module cam_ctrl
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int TOMBSTONE  = tombstone_of(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ins_valid,
    input  logic [DATA_WIDTH-1:0] ins_data,
    output logic                  ins_ready,
    input  logic                  del_valid,
    input  logic [ADDR_WIDTH-1:0] del_addr,
    output logic                  del_ready,
    input  logic                  lk_valid,
    input  logic [DATA_WIDTH-1:0] lk_data,
    output logic                  lk_ready,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] res_addr,
    output logic                  res_hit,
    output logic                  res_dup,
    output logic                  res_err,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  init_busy,
    output logic                  cam_we,
    output logic [DATA_WIDTH-1:0] cam_din,
    output logic [ADDR_WIDTH-1:0] cam_waddr,
    output logic [DATA_WIDTH-1:0] cam_cmp_din,
    input  logic                  cam_busy,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

    localparam int                    DEPTH     = 2**ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] TOMB      = DATA_WIDTH'(TOMBSTONE);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    state_t                state_q, state_d;
    op_t                   op_q, op_d;
    logic [ADDR_WIDTH-1:0] init_idx_q, init_idx_d;
    logic [DATA_WIDTH-1:0] key_q, key_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  cmp_wait_q, cmp_wait_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  last_ins_q, last_ins_d;
    logic                  ins_ready_q, ins_ready_d;
    logic                  del_ready_q, del_ready_d;
    logic                  lk_ready_q, lk_ready_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] res_addr_q, res_addr_d;
    logic                  res_hit_q, res_hit_d;
    logic                  res_dup_q, res_dup_d;
    logic                  res_err_q, res_err_d;
    logic                  init_busy_q, init_busy_d;
    logic                  cam_we_q, cam_we_d;
    logic [DATA_WIDTH-1:0] cam_din_q, cam_din_d;
    logic [ADDR_WIDTH-1:0] cam_waddr_q, cam_waddr_d;
    logic [DATA_WIDTH-1:0] cam_cmp_din_q, cam_cmp_din_d;

    logic [ADDR_WIDTH-1:0] w_free_idx;
    logic                  w_any_free;
    logic                  w_hit;
    logic                  w_fin;
    logic                  w_fin_err;
    logic                  w_fin_hit;
    logic                  w_fin_dup;
    logic [ADDR_WIDTH-1:0] w_fin_addr;

    cam_free_enc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_free_enc (
        .valid    (valid_q),
        .idx      (w_free_idx),
        .any_free (w_any_free)
    );

    // A CAM match on a stale (tombstoned) slot must not count as a hit.
    assign w_hit = cam_match && valid_q[cam_match_addr];

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        init_idx_d    = init_idx_q;
        key_d         = key_q;
        addr_d        = addr_q;
        cmp_wait_d    = cmp_wait_q;
        valid_d       = valid_q;
        count_d       = count_q;
        last_ins_d    = last_ins_q;
        ins_ready_d   = 1'b0;
        del_ready_d   = 1'b0;
        lk_ready_d    = 1'b0;
        done_d        = 1'b0;
        res_addr_d    = res_addr_q;
        res_hit_d     = res_hit_q;
        res_dup_d     = res_dup_q;
        res_err_d     = res_err_q;
        init_busy_d   = init_busy_q;
        cam_we_d      = 1'b0;
        cam_din_d     = cam_din_q;
        cam_waddr_d   = cam_waddr_q;
        cam_cmp_din_d = cam_cmp_din_q;
        w_fin         = 1'b0;
        w_fin_err     = 1'b0;
        w_fin_hit     = 1'b0;
        w_fin_dup     = 1'b0;
        w_fin_addr    = '0;

        case (state_q)
            ST_INIT: begin
                if (!cam_busy) begin
                    cam_we_d    = 1'b1;
                    cam_din_d   = TOMB;
                    cam_waddr_d = init_idx_q;
                    op_d        = OP_INIT;
                    state_d     = ST_WAIT_BUSY;
                end
            end
            ST_IDLE: begin
                if (del_valid && del_ready_q) begin
                    op_d   = OP_DEL;
                    addr_d = del_addr;
                    if (valid_q[del_addr]) begin
                        state_d = ST_WR;
                    end else begin
                        w_fin      = 1'b1;
                        w_fin_err  = 1'b1;
                        w_fin_addr = del_addr;
                    end
                end else if (ins_valid && ins_ready_q) begin
                    op_d       = OP_INS;
                    key_d      = ins_data;
                    last_ins_d = 1'b1;
                    if (ins_data == TOMB) begin
                        w_fin     = 1'b1;
                        w_fin_err = 1'b1;
                    end else begin
                        cam_cmp_din_d = ins_data;
                        cmp_wait_d    = 1'b0;
                        state_d       = ST_CMP;
                    end
                end else if (lk_valid && lk_ready_q) begin
                    op_d       = OP_LK;
                    key_d      = lk_data;
                    last_ins_d = 1'b0;
                    if (lk_data == TOMB) begin
                        w_fin = 1'b1;
                    end else begin
                        cam_cmp_din_d = lk_data;
                        cmp_wait_d    = 1'b0;
                        state_d       = ST_CMP;
                    end
                end else if (!cam_busy) begin
                    if (del_valid) begin
                        del_ready_d = 1'b1;
                    end else if (ins_valid && lk_valid) begin
                        lk_ready_d  = last_ins_q;
                        ins_ready_d = !last_ins_q;
                    end else begin
                        ins_ready_d = ins_valid;
                        lk_ready_d  = lk_valid;
                    end
                end
            end
            ST_CMP: begin
                // First cycle presents the key; the CAM answers in the second.
                if (!cmp_wait_q) begin
                    cmp_wait_d = 1'b1;
                end else if (op_q == OP_LK) begin
                    w_fin      = 1'b1;
                    w_fin_hit  = w_hit;
                    w_fin_addr = w_hit ? cam_match_addr : '0;
                end else if (w_hit) begin
                    w_fin      = 1'b1;
                    w_fin_dup  = 1'b1;
                    w_fin_addr = cam_match_addr;
                end else if (!w_any_free) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end else begin
                    addr_d  = w_free_idx;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (!cam_busy) begin
                    cam_we_d    = 1'b1;
                    cam_waddr_d = addr_q;
                    state_d     = ST_WAIT_BUSY;
                    if (op_q == OP_DEL) begin
                        cam_din_d       = TOMB;
                        valid_d[addr_q] = 1'b0;
                        count_d         = count_q - CNT_ONE;
                    end else begin
                        cam_din_d       = key_q;
                        valid_d[addr_q] = 1'b1;
                        count_d         = count_q + CNT_ONE;
                    end
                end
            end
            ST_WAIT_BUSY: begin
                // Skip the strobe cycle itself: the CAM raises busy only after it.
                if (!cam_we_q && !cam_busy) begin
                    if (op_q != OP_INIT) begin
                        w_fin      = 1'b1;
                        w_fin_addr = addr_q;
                    end else if (init_idx_q == LAST_IDX) begin
                        init_busy_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        init_idx_d = init_idx_q + 1'b1;
                        state_d    = ST_INIT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (w_fin) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            res_err_d  = w_fin_err;
            res_hit_d  = w_fin_hit;
            res_dup_d  = w_fin_dup;
            res_addr_d = w_fin_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            op_q        <= OP_INIT;
            init_idx_q  <= '0;
            cmp_wait_q  <= 1'b0;
            valid_q     <= '0;
            count_q     <= '0;
            last_ins_q  <= 1'b0;
            ins_ready_q <= 1'b0;
            del_ready_q <= 1'b0;
            lk_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            res_addr_q  <= '0;
            res_hit_q   <= 1'b0;
            res_dup_q   <= 1'b0;
            res_err_q   <= 1'b0;
            init_busy_q <= 1'b1;
            cam_we_q    <= 1'b0;
            cam_din_q   <= '0;
            cam_waddr_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            init_idx_q  <= init_idx_d;
            cmp_wait_q  <= cmp_wait_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            last_ins_q  <= last_ins_d;
            ins_ready_q <= ins_ready_d;
            del_ready_q <= del_ready_d;
            lk_ready_q  <= lk_ready_d;
            done_q      <= done_d;
            res_addr_q  <= res_addr_d;
            res_hit_q   <= res_hit_d;
            res_dup_q   <= res_dup_d;
            res_err_q   <= res_err_d;
            init_busy_q <= init_busy_d;
            cam_we_q    <= cam_we_d;
            cam_din_q   <= cam_din_d;
            cam_waddr_q <= cam_waddr_d;
        end
    end

    // Request payload and compare key are left unreset so a reset never
    // disturbs the compare bus while the CAM may still be busy.
    always_ff @(posedge clk) begin
        key_q         <= key_d;
        addr_q        <= addr_d;
        cam_cmp_din_q <= cam_cmp_din_d;
    end

    assign ins_ready   = ins_ready_q;
    assign del_ready   = del_ready_q;
    assign lk_ready    = lk_ready_q;
    assign done        = done_q;
    assign res_addr    = res_addr_q;
    assign res_hit     = res_hit_q;
    assign res_dup     = res_dup_q;
    assign res_err     = res_err_q;
    assign count       = count_q;
    assign full        = (count_q == DEPTH_CNT);
    assign init_busy   = init_busy_q;
    assign cam_we      = cam_we_q;
    assign cam_din     = cam_din_q;
    assign cam_waddr   = cam_waddr_q;
    assign cam_cmp_din = cam_cmp_din_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_ctrl
// Purpose  : Directed self-checking bench for cam_ctrl with a behavioural CAM.
// Revision : 1.0
// ============================================================================
module tb_cam_ctrl;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       ins_valid = 1'b0;
    logic [3:0] ins_data  = '0;
    logic       del_valid = 1'b0;
    logic [1:0] del_addr  = '0;
    logic       lk_valid  = 1'b0;
    logic [3:0] lk_data   = '0;
    logic       ins_ready, del_ready, lk_ready;
    logic       done, res_hit, res_dup, res_err, full, init_busy;
    logic [1:0] res_addr;
    logic [2:0] count;
    logic       cam_we;
    logic [3:0] cam_din, cam_cmp_din;
    logic [1:0] cam_waddr;
    logic       cam_busy;
    logic       cam_match      = 1'b0;
    logic [1:0] cam_match_addr = '0;

    int checks = 0;
    int errors = 0;

    logic [3:0] mem [4] = '{default: 4'd0};
    int         busy_lat = 0;
    int         busy_cnt = 0;
    int         we_cnt   = 0;
    int         done_cnt = 0;
    int         viol     = 0;
    int         wl_addr [$];
    int         wl_data [$];
    int         gq [$];
    logic [3:0] prev_cmp;
    logic       m_v;
    logic [1:0] ma_v;

    cam_ctrl #(
        .DATA_WIDTH (4),
        .ADDR_WIDTH (2),
        .TOMBSTONE  (15)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ins_valid      (ins_valid),
        .ins_data       (ins_data),
        .ins_ready      (ins_ready),
        .del_valid      (del_valid),
        .del_addr       (del_addr),
        .del_ready      (del_ready),
        .lk_valid       (lk_valid),
        .lk_data        (lk_data),
        .lk_ready       (lk_ready),
        .done           (done),
        .res_addr       (res_addr),
        .res_hit        (res_hit),
        .res_dup        (res_dup),
        .res_err        (res_err),
        .count          (count),
        .full           (full),
        .init_busy      (init_busy),
        .cam_we         (cam_we),
        .cam_din        (cam_din),
        .cam_waddr      (cam_waddr),
        .cam_cmp_din    (cam_cmp_din),
        .cam_busy       (cam_busy),
        .cam_match      (cam_match),
        .cam_match_addr (cam_match_addr)
    );

    always #5 clk = ~clk;

    assign cam_busy = (busy_cnt != 0);

    // Behavioural CAM: one-cycle compare, programmable busy after each write.
    always @(posedge clk) begin
        m_v  = 1'b0;
        ma_v = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mem[i] === cam_cmp_din) begin
                m_v  = 1'b1;
                ma_v = 2'(i);
            end
        end
        cam_match      <= m_v;
        cam_match_addr <= ma_v;
        if (cam_we === 1'b1) begin
            mem[cam_waddr] <= cam_din;
            busy_cnt       <= busy_lat;
            we_cnt         <= we_cnt + 1;
            wl_addr.push_back(int'(cam_waddr));
            wl_data.push_back(int'(cam_din));
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (cam_busy && cam_we === 1'b1) viol <= viol + 1;
        if (cam_busy && cam_cmp_din !== prev_cmp) viol <= viol + 1;
        prev_cmp <= cam_cmp_din;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (ins_valid && ins_ready === 1'b1) gq.push_back(1);
        if (lk_valid && lk_ready === 1'b1) gq.push_back(2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int k);
        case (k)
            0:       return ins_ready;
            1:       return del_ready;
            default: return lk_ready;
        endcase
    endfunction

    // kind: 0 insert, 1 delete, 2 lookup. Returns cycles from accept to done.
    task automatic req(input int kind, input logic [3:0] val, output int lat, output int nwe);
        int cyc;
        int we0;
        @(negedge clk);
        we0 = we_cnt;
        case (kind)
            0:       begin ins_valid = 1'b1; ins_data = val;      end
            1:       begin del_valid = 1'b1; del_addr = val[1:0]; end
            default: begin lk_valid  = 1'b1; lk_data  = val;      end
        endcase
        cyc = 0;
        while (!rdy(kind) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("accept_timeout", 32'(cyc < 50), 1);
        @(negedge clk);
        ins_valid = 1'b0;
        del_valid = 1'b0;
        lk_valid  = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_timeout", 32'(cyc < 50), 1);
        lat = cyc;
        nwe = we_cnt - we0;
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    task automatic wait_init(input string tag);
        int cyc;
        cyc = 0;
        while (init_busy !== 1'b0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, 32'(cyc < 300), 1);
        chk("init_nwrites", wl_addr.size(), 4);
        for (int i = 0; i < wl_addr.size() && i < 4; i++) begin
            chk("init_waddr", wl_addr[i], i);
            chk("init_wdata", wl_data[i], 15);
        end
        chk("init_count", count, 0);
    endtask

    initial begin
        int lat, nwe, cyc, d0, we0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_init_busy", init_busy, 1);
        chk("rst_count", count, 0);
        chk("rst_done", done, 0);
        chk("rst_cam_we", cam_we, 0);
        chk("rst_readies", {ins_ready, del_ready, lk_ready}, 0);
        wl_addr.delete();
        wl_data.delete();
        rst = 1'b1;
        @(negedge clk);
        chk("init_busy_run", init_busy, 1);
        wait_init("init_timeout");
        chk("init_full", full, 0);

        req(0, 4'd6, lat, nwe); chk("ins6_addr", res_addr, 0); chk("ins6_err", res_err, 0); chk("ins6_we", nwe, 1);
        req(0, 4'd9, lat, nwe); chk("ins9_addr", res_addr, 1); chk("ins9_dup", res_dup, 0);
        req(0, 4'd4, lat, nwe); chk("ins4_addr", res_addr, 2);
        req(0, 4'd3, lat, nwe); chk("ins3_addr", res_addr, 3);
        chk("fill_count", count, 4);
        chk("fill_full", full, 1);

        req(0, 4'd7, lat, nwe); chk("full_err", res_err, 1); chk("full_nwe", nwe, 0); chk("full_count", count, 4);
        req(0, 4'd9, lat, nwe); chk("dup_flag", res_dup, 1); chk("dup_addr", res_addr, 1);
        chk("dup_err", res_err, 0); chk("dup_nwe", nwe, 0);
        req(0, 4'd15, lat, nwe); chk("ins_tomb_err", res_err, 1); chk("ins_tomb_nwe", nwe, 0);

        req(2, 4'd4, lat, nwe); chk("lk4_hit", res_hit, 1); chk("lk4_addr", res_addr, 2);
        req(2, 4'd5, lat, nwe); chk("lk5_hit", res_hit, 0);
        req(2, 4'd15, lat, nwe); chk("lk15_hit", res_hit, 0); chk("lk15_nocmp_lat", lat, 1);

        req(1, 4'd1, lat, nwe);
        chk("del1_nwe", nwe, 1);
        chk("del1_waddr", wl_addr[wl_addr.size() - 1], 1);
        chk("del1_wdata", wl_data[wl_data.size() - 1], 15);
        chk("del1_count", count, 3);
        chk("del1_full", full, 0);
        chk("del1_err", res_err, 0);
        req(2, 4'd9, lat, nwe); chk("lk9_miss", res_hit, 0);
        req(0, 4'd13, lat, nwe); chk("ins13_addr", res_addr, 1); chk("ins13_count", count, 4);
        req(1, 4'd1, lat, nwe); chk("del1b_count", count, 3);
        req(1, 4'd1, lat, nwe); chk("del_inv_err", res_err, 1); chk("del_inv_nwe", nwe, 0);
        chk("del_inv_count", count, 3);

        // Insert and lookup held together; insert was granted last.
        @(negedge clk);
        gq.delete();
        d0 = done_cnt;
        ins_valid = 1'b1; ins_data = 4'd8;
        lk_valid  = 1'b1; lk_data  = 4'd4;
        cyc = 0;
        while (gq.size() < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        ins_valid = 1'b0;
        lk_valid  = 1'b0;
        chk("rr_timeout", 32'(cyc < 200), 1);
        repeat (6) @(negedge clk);
        chk("rr_ngrants", gq.size(), 4);
        for (int i = 0; i < gq.size() && i < 4; i++) chk("rr_order", gq[i], (i % 2 == 0) ? 2 : 1);
        chk("rr_dones", done_cnt - d0, 4);
        chk("rr_count", count, 4);
        chk("rr_last_dup", res_dup, 1);
        chk("rr_last_addr", res_addr, 1);

        busy_lat = 3;
        req(1, 4'd1, lat, nwe);
        chk("busy_del_lat", lat, 7);
        chk("busy_del_nwe", nwe, 1);
        chk("busy_del_count", count, 3);
        chk("busy_violations", viol, 0);

        // Reset while an insert waits on cam_busy.
        @(negedge clk);
        d0  = done_cnt;
        we0 = we_cnt;
        ins_valid = 1'b1; ins_data = 4'd10;
        cyc = 0;
        while (!ins_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        ins_valid = 1'b0;
        cyc = 0;
        while (we_cnt == we0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_we_timeout", 32'(cyc < 50), 1);
        chk("mid_busy_seen", cam_busy, 1);
        rst = 1'b0;
        wl_addr.delete();
        wl_data.delete();
        repeat (2) @(negedge clk);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_init_busy", init_busy, 1);
        chk("mid_rst_done", done, 0);
        rst = 1'b1;
        wait_init("reinit_timeout");
        chk("mid_no_done", done_cnt - d0, 0);
        req(2, 4'd6, lat, nwe); chk("post_rst_lk6", res_hit, 0);
        chk("final_violations", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
